// File: rtl/pwm_multi.sv
// Multi-channel PWM generator.
// One shared prescaler and period counter drive CHANNELS comparators. The
// counter runs edge-aligned (0..P, wrap) or center-aligned (0..P..1).
// Period, mode and duty values are double-buffered. The live ("act") copies
// reload only at a period boundary, or continuously while the block is
// disabled, so a period never runs with mixed settings.
module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PRESC_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        mode,
    input  logic [PRESC_W-1:0]          prescale,
    input  logic [WIDTH-1:0]            period,
    input  logic                        wr_en,
    input  logic [$clog2(CHANNELS)-1:0] wr_ch,
    input  logic [WIDTH-1:0]            wr_dc,
    output logic [CHANNELS-1:0]         pwm_out,
    output logic [CHANNELS-1:0]         pwm_out_n,
    output logic                        period_end
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [PRESC_W-1:0] r_presc_cnt;
    logic [WIDTH-1:0]   r_cnt;
    logic [WIDTH-1:0]   w_cnt_next;
    dir_t               r_dir;
    dir_t               w_dir_next;
    logic [WIDTH-1:0]   r_period_act;
    logic               r_mode_act;
    logic               r_period_end;
    logic               w_tick;
    logic               w_boundary;
    logic               w_load;
    logic               w_wr_ok;

    // A prescale value lowered below the running count gives no tick:
    // the count simply restarts from 0 on the next cycle.
    assign w_tick  = en && (r_presc_cnt == prescale);
    assign w_load  = !en || w_boundary;
    assign w_wr_ok = wr_en && (int'(wr_ch) < CHANNELS);

    // Prescaler: counts 0..prescale and clears when disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc_cnt <= '0;
        end else if (!en || r_presc_cnt >= prescale) begin
            r_presc_cnt <= '0;
        end else begin
            r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
        end
    end

    // Boundary detection. Edge mode ends a period on the tick at the top
    // count. Center mode ends it on the tick that sees the count back at 0
    // while descending, or on every tick when the period is 0.
    always_comb begin
        w_boundary = 1'b0;
        if (w_tick) begin
            if (!r_mode_act) begin
                w_boundary = (r_cnt == r_period_act);
            end else begin
                w_boundary = (r_period_act == '0) ||
                             ((r_cnt == '0) && (r_dir == DIR_DOWN));
            end
        end
    end

    // Counter and direction next-state. In center mode the 0 seen at a
    // boundary already counts as the first tick of the new period, so
    // center->center continues at 1. Any other transition restarts at 0
    // counting up.
    always_comb begin
        w_cnt_next = r_cnt;
        w_dir_next = r_dir;
        if (!en) begin
            w_cnt_next = '0;
            w_dir_next = DIR_UP;
        end else if (w_boundary) begin
            w_dir_next = DIR_UP;
            if (r_mode_act && mode && (period != '0)) begin
                w_cnt_next = WIDTH'(1);
            end else begin
                w_cnt_next = '0;
            end
        end else if (w_tick) begin
            if (!r_mode_act) begin
                w_cnt_next = r_cnt + WIDTH'(1);
            end else if (r_dir == DIR_UP) begin
                if (r_cnt >= r_period_act) begin
                    w_cnt_next = r_cnt - WIDTH'(1);
                    w_dir_next = DIR_DOWN;
                end else begin
                    w_cnt_next = r_cnt + WIDTH'(1);
                end
            end else begin
                w_cnt_next = r_cnt - WIDTH'(1);
            end
        end
    end

    // Counter and direction state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_dir <= DIR_UP;
        end else begin
            r_cnt <= w_cnt_next;
            r_dir <= w_dir_next;
        end
    end

    // Shadow period and mode: reload at a boundary or while disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period_act <= '0;
            r_mode_act   <= 1'b0;
        end else if (w_load) begin
            r_period_act <= period;
            r_mode_act   <= mode;
        end
    end

    // Period-end pulse, one clk after the boundary tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period_end <= 1'b0;
        end else begin
            r_period_end <= w_boundary;
        end
    end

    assign period_end = r_period_end;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] r_dc_buf;
            logic [WIDTH-1:0] r_dc_act;
            logic             r_pwm;
            logic             r_pwm_n;
            logic             w_below;

            assign w_below = (r_cnt < r_dc_act);

            // Duty staging buffer. Writes are accepted even while disabled.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_dc_buf <= '0;
                end else if (w_wr_ok && (int'(wr_ch) == gi)) begin
                    r_dc_buf <= wr_dc;
                end
            end

            // Active duty. It takes the buffer value from before any
            // same-cycle write, so there is no bypass at a boundary.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_dc_act <= '0;
                end else if (w_load) begin
                    r_dc_act <= r_dc_buf;
                end
            end

            // Registered comparator outputs, forced low while disabled.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_pwm   <= 1'b0;
                    r_pwm_n <= 1'b0;
                end else begin
                    r_pwm   <= en && w_below;
                    r_pwm_n <= en && !w_below;
                end
            end

            assign pwm_out[gi]   = r_pwm;
            assign pwm_out_n[gi] = r_pwm_n;
        end
    endgenerate

endmodule

// File: tb/tb_pwm_multi.sv
// Testbench for pwm_multi.
// Each cycle, a reference model tracks the position inside the current PWM
// period and predicts the outputs. Directed duty and period counts come
// from the expected waveform shapes. Three channels are used so that
// wr_ch == 3 is out of range.
module tb_pwm_multi;
    localparam int WIDTH    = 8;
    localparam int CHANNELS = 3;
    localparam int PRESC_W  = 4;

    logic                clk;
    logic                reset;
    logic                en;
    logic                mode;
    logic [PRESC_W-1:0]  prescale;
    logic [WIDTH-1:0]    period;
    logic                wr_en;
    logic [1:0]          wr_ch;
    logic [WIDTH-1:0]    wr_dc;
    logic [CHANNELS-1:0] pwm_out;
    logic [CHANNELS-1:0] pwm_out_n;
    logic                period_end;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: position within the period, not counter/dir.
    int m_presc, m_pos, m_P;
    bit m_first, m_mode;
    int m_dca [CHANNELS];
    int m_dcb [CHANNELS];
    logic [CHANNELS-1:0] e_pwm, e_pwmn;
    logic                e_pe;

    pwm_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .PRESC_W(PRESC_W)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .prescale(prescale),
        .period(period), .wr_en(wr_en), .wr_ch(wr_ch), .wr_dc(wr_dc),
        .pwm_out(pwm_out), .pwm_out_n(pwm_out_n), .period_end(period_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model update from the current inputs, then one clock edge, then settle.
    task automatic step();
        int  cnt;
        bit  tick, bnd;
        if (reset) begin
            m_presc = 0; m_pos = 0; m_P = 0; m_first = 1; m_mode = 0;
            for (int i = 0; i < CHANNELS; i++) begin
                m_dca[i] = 0; m_dcb[i] = 0;
            end
            e_pwm = '0; e_pwmn = '0; e_pe = 1'b0;
        end else begin
            if (m_mode) cnt = (m_pos <= m_P) ? m_pos : 2 * m_P - m_pos;
            else        cnt = m_pos;
            for (int i = 0; i < CHANNELS; i++) begin
                e_pwm[i]  = en && (cnt < m_dca[i]);
                e_pwmn[i] = en && !(cnt < m_dca[i]);
            end
            tick = en && (m_presc == int'(prescale));
            if (!m_mode) bnd = tick && (m_pos == m_P);
            else         bnd = tick && ((m_P == 0) || (m_pos == 0 && !m_first));
            e_pe = bnd;
            if (!en) begin
                m_pos = 0; m_first = 1;
            end else if (bnd) begin
                if (m_mode && mode && period != 0) begin m_pos = 1; m_first = 0; end
                else begin m_pos = 0; m_first = 1; end
            end else if (tick) begin
                if (!m_mode) m_pos++;
                else begin m_pos = (m_pos + 1) % (2 * m_P); m_first = 0; end
            end
            if (!en || bnd) begin
                m_P = int'(period); m_mode = mode; m_dca = m_dcb;
            end
            if (wr_en && int'(wr_ch) < CHANNELS) m_dcb[int'(wr_ch)] = int'(wr_dc);
            m_presc = (!en || m_presc >= int'(prescale)) ? 0 : m_presc + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; mode = 1'b0; prescale = '0; period = '0;
        wr_en = 1'b0; wr_ch = '0; wr_dc = '0;
        step();
        step();
        n_cmp++;
        if (pwm_out !== 3'b000) begin n_err++; $display("FAIL reset_pwm got=%b exp=000", pwm_out); end
        n_cmp++;
        if (pwm_out_n !== 3'b000) begin n_err++; $display("FAIL reset_pwmn got=%b exp=000", pwm_out_n); end
        n_cmp++;
        if (period_end !== 1'b0) begin n_err++; $display("FAIL reset_pe got=%b exp=0", period_end); end
        $display("test_reset: outputs pwm=%b n=%b pe=%b", pwm_out, pwm_out_n, period_end);
    endtask

    // Edge mode, period 9: duties 3, 0 and 10 (above the period).
    task automatic test_edge();
        int hi0 = 0, hi1 = 0, hi2 = 0, lo2n = 0, pe = 0;
        reset = 1'b0; en = 1'b0; mode = 1'b0; prescale = '0; period = 8'd9;
        for (int k = 0; k < 44; k++) begin
            wr_en = (k < 3);
            wr_ch = 2'(k);
            wr_dc = (k == 0) ? 8'd3 : (k == 1) ? 8'd0 : 8'd10;
            en    = (k >= 4);
            step();
            n_cmp++;
            if (pwm_out !== e_pwm) begin n_err++; $display("FAIL edge_pwm cyc=%0d got=%b exp=%b", k, pwm_out, e_pwm); end
            n_cmp++;
            if (pwm_out_n !== e_pwmn) begin n_err++; $display("FAIL edge_pwmn cyc=%0d got=%b exp=%b", k, pwm_out_n, e_pwmn); end
            n_cmp++;
            if (period_end !== e_pe) begin n_err++; $display("FAIL edge_pe cyc=%0d got=%b exp=%b", k, period_end, e_pe); end
            if (k >= 14) begin
                hi0 += int'(pwm_out[0]); hi1 += int'(pwm_out[1]);
                hi2 += int'(pwm_out[2]); lo2n += int'(pwm_out_n[2]);
                pe  += int'(period_end);
            end
        end
        n_cmp++;
        if (hi0 != 9) begin n_err++; $display("FAIL edge_hi0 got=%0d exp=9", hi0); end
        n_cmp++;
        if (pe != 3) begin n_err++; $display("FAIL edge_pe_count got=%0d exp=3", pe); end
        n_cmp++;
        if (hi1 != 0) begin n_err++; $display("FAIL edge_dc0_low got=%0d exp=0", hi1); end
        n_cmp++;
        if (hi2 != 30) begin n_err++; $display("FAIL edge_dcbig_high got=%0d exp=30", hi2); end
        n_cmp++;
        if (lo2n != 0) begin n_err++; $display("FAIL edge_dcbig_n got=%0d exp=0", lo2n); end
        $display("test_edge: 30-cycle window hi0=%0d hi1=%0d hi2=%0d pe=%0d", hi0, hi1, hi2, pe);
    endtask

    // Center mode, period 4, duty 2.
    task automatic test_center();
        int hi0 = 0, pe = 0;
        en = 1'b0; mode = 1'b1; prescale = '0; period = 8'd4;
        wr_en = 1'b1; wr_ch = 2'd0; wr_dc = 8'd2;
        step();
        wr_en = 1'b0;
        step();
        for (int k = 0; k < 48; k++) begin
            en = 1'b1;
            step();
            n_cmp++;
            if (pwm_out !== e_pwm) begin n_err++; $display("FAIL center_pwm cyc=%0d got=%b exp=%b", k, pwm_out, e_pwm); end
            n_cmp++;
            if (pwm_out_n !== e_pwmn) begin n_err++; $display("FAIL center_pwmn cyc=%0d got=%b exp=%b", k, pwm_out_n, e_pwmn); end
            n_cmp++;
            if (period_end !== e_pe) begin n_err++; $display("FAIL center_pe cyc=%0d got=%b exp=%b", k, period_end, e_pe); end
            if (k >= 16) begin hi0 += int'(pwm_out[0]); pe += int'(period_end); end
        end
        n_cmp++;
        if (hi0 != 12) begin n_err++; $display("FAIL center_hi0 got=%0d exp=12", hi0); end
        n_cmp++;
        if (pe != 4) begin n_err++; $display("FAIL center_pe_count got=%0d exp=4", pe); end
        $display("test_center: 32-cycle window hi0=%0d pe=%0d", hi0, pe);
    endtask

    // Edge mode, prescale 2, period 1, duty 1: 3 cycles high, 3 cycles low.
    task automatic test_prescale();
        int hi0 = 0;
        en = 1'b0; mode = 1'b0; prescale = 4'd2; period = 8'd1;
        wr_en = 1'b1; wr_ch = 2'd0; wr_dc = 8'd1;
        step();
        wr_en = 1'b0;
        step();
        for (int k = 0; k < 36; k++) begin
            en = 1'b1;
            step();
            n_cmp++;
            if (pwm_out !== e_pwm) begin n_err++; $display("FAIL presc_pwm cyc=%0d got=%b exp=%b", k, pwm_out, e_pwm); end
            n_cmp++;
            if (period_end !== e_pe) begin n_err++; $display("FAIL presc_pe cyc=%0d got=%b exp=%b", k, period_end, e_pe); end
            if (k >= 6) hi0 += int'(pwm_out[0]);
        end
        n_cmp++;
        if (hi0 != 15) begin n_err++; $display("FAIL presc_hi0 got=%0d exp=15", hi0); end
        $display("test_prescale: 30-cycle window hi0=%0d", hi0);
    endtask

    // Duty writes mid-period and on a boundary take effect one boundary later.
    task automatic test_duty_update();
        int h0 = 0, h1 = 0, h2 = 0;
        en = 1'b0; mode = 1'b0; prescale = '0; period = 8'd9;
        wr_en = 1'b1; wr_ch = 2'd0; wr_dc = 8'd3;
        step();
        wr_en = 1'b0;
        step();
        for (int k = 0; k < 40; k++) begin
            en = 1'b1;
            wr_en = (k == 4) || (k == 9);
            wr_ch = 2'd0;
            wr_dc = (k == 4) ? 8'd5 : 8'd7;
            step();
            n_cmp++;
            if (pwm_out !== e_pwm) begin n_err++; $display("FAIL duty_pwm cyc=%0d got=%b exp=%b", k, pwm_out, e_pwm); end
            n_cmp++;
            if (period_end !== e_pe) begin n_err++; $display("FAIL duty_pe cyc=%0d got=%b exp=%b", k, period_end, e_pe); end
            if (k < 10) h0 += int'(pwm_out[0]);
            else if (k < 20) h1 += int'(pwm_out[0]);
            else h2 += int'(pwm_out[0]);
        end
        wr_en = 1'b0;
        n_cmp++;
        if (h0 != 3) begin n_err++; $display("FAIL duty_first got=%0d exp=3", h0); end
        n_cmp++;
        if (h1 != 5) begin n_err++; $display("FAIL duty_nobypass got=%0d exp=5", h1); end
        n_cmp++;
        if (h2 != 14) begin n_err++; $display("FAIL duty_new got=%0d exp=14", h2); end
        $display("test_duty_update: high counts %0d / %0d / %0d", h0, h1, h2);
    endtask

    // Random settings, writes (including out-of-range), enable drops and
    // prescale changes, checked every cycle against the model.
    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            en = 1'b0;
            mode = 1'($urandom_range(1));
            prescale = 4'($urandom_range(3));
            period = 8'($urandom_range(12));
            for (int c = 0; c < CHANNELS + 1; c++) begin
                wr_en = 1'b1; wr_ch = 2'(c); wr_dc = 8'($urandom_range(14));
                step();
            end
            wr_en = 1'b0;
            step();
            en = 1'b1;
            for (int k = 0; k < 160; k++) begin
                wr_en = ($urandom_range(5) == 0);
                wr_ch = 2'($urandom_range(3));
                wr_dc = 8'($urandom_range(14));
                if ($urandom_range(29) == 0) period = 8'($urandom_range(12));
                if ($urandom_range(59) == 0) mode = ~mode;
                if ($urandom_range(24) == 0) prescale = 4'($urandom_range(6));
                if ($urandom_range(39) == 0) en = ~en;
                step();
                n_cmp++;
                if (pwm_out !== e_pwm) begin n_err++; $display("FAIL rand_pwm run=%0d cyc=%0d got=%b exp=%b", r, k, pwm_out, e_pwm); end
                n_cmp++;
                if (pwm_out_n !== e_pwmn) begin n_err++; $display("FAIL rand_pwmn run=%0d cyc=%0d got=%b exp=%b", r, k, pwm_out_n, e_pwmn); end
                n_cmp++;
                if (period_end !== e_pe) begin n_err++; $display("FAIL rand_pe run=%0d cyc=%0d got=%b exp=%b", r, k, period_end, e_pe); end
            end
            $display("test_random: run %0d mode=%0d period=%0d prescale=%0d done", r, mode, period, prescale);
        end
        wr_en = 1'b0;
    endtask

    // Reset mid-period (and mid-write) with outputs high.
    task automatic test_reset_mid();
        en = 1'b0; mode = 1'b0; prescale = '0; period = 8'd9;
        wr_en = 1'b1; wr_ch = 2'd0; wr_dc = 8'd3;
        step();
        wr_en = 1'b0;
        step();
        en = 1'b1;
        step();
        step();
        n_cmp++;
        if (pwm_out[0] !== 1'b1) begin n_err++; $display("FAIL rmid_pre got=%b exp=1", pwm_out[0]); end
        reset = 1'b1; wr_en = 1'b1; wr_ch = 2'd1; wr_dc = 8'd9;
        step();
        n_cmp++;
        if ({pwm_out, pwm_out_n, period_end} !== 7'b0) begin
            n_err++; $display("FAIL rmid_zero got=%b%b%b exp=0000000", pwm_out, pwm_out_n, period_end);
        end
        reset = 1'b0; wr_en = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            n_cmp++;
            if (pwm_out !== 3'b000) begin n_err++; $display("FAIL rmid_pwm cyc=%0d got=%b exp=000", k, pwm_out); end
            n_cmp++;
            if (pwm_out_n !== 3'b111) begin n_err++; $display("FAIL rmid_pwmn cyc=%0d got=%b exp=111", k, pwm_out_n); end
            n_cmp++;
            if (period_end !== e_pe) begin n_err++; $display("FAIL rmid_pe cyc=%0d got=%b exp=%b", k, period_end, e_pe); end
        end
        $display("test_reset_mid: after release pwm=%b n=%b", pwm_out, pwm_out_n);
    endtask

    initial begin
        test_reset();
        test_edge();
        test_center();
        test_prescale();
        test_duty_update();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
